// File: rtl/bcd_counter_7seg_mux.sv
// Multi-digit BCD up/down counter with synchronous load, wrap/borrow pulse and a
// time-multiplexed 7-segment driver (shared seg bus, one-hot digit select).
module bcd_counter_7seg_mux #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up_down,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                carry,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7_decode = 7'b0111111;
            4'd1:    seg7_decode = 7'b0000110;
            4'd2:    seg7_decode = 7'b1011011;
            4'd3:    seg7_decode = 7'b1001111;
            4'd4:    seg7_decode = 7'b1100110;
            4'd5:    seg7_decode = 7'b1101101;
            4'd6:    seg7_decode = 7'b1111101;
            4'd7:    seg7_decode = 7'b0000111;
            4'd8:    seg7_decode = 7'b1111111;
            4'd9:    seg7_decode = 7'b1101111;
            default: seg7_decode = 7'b0000000;
        endcase
    endfunction

    logic [4*DIGITS-1:0] count_r;
    logic [4*DIGITS-1:0] next_count_s;
    logic                carry_r;
    logic                next_carry_s;
    logic                ripple_s;
    logic [3:0]          nib_s;
    logic [PRE_W-1:0]    pre_r;
    logic [IDX_W-1:0]    scan_r;
    logic [3:0]          digit_s;
    logic [6:0]          seg_raw_s;
    logic [DIGITS-1:0]   an_raw_s;

    // Next count: load clamps bad nibbles to 0, a step ripples from digit 0 upward.
    always_comb begin
        next_count_s = count_r;
        next_carry_s = 1'b0;
        ripple_s     = 1'b1;
        nib_s        = 4'd0;
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib_s = load_val[4*i +: 4];
                next_count_s[4*i +: 4] = (nib_s > 4'd9) ? 4'd0 : nib_s;
            end
        end else if (en) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib_s = count_r[4*i +: 4];
                if (!ripple_s) begin
                    next_count_s[4*i +: 4] = nib_s;
                end else if (up_down) begin
                    if (nib_s == 4'd9) begin
                        next_count_s[4*i +: 4] = 4'd0;
                    end else begin
                        next_count_s[4*i +: 4] = nib_s + 4'd1;
                        ripple_s = 1'b0;
                    end
                end else begin
                    if (nib_s == 4'd0) begin
                        next_count_s[4*i +: 4] = 4'd9;
                    end else begin
                        next_count_s[4*i +: 4] = nib_s - 4'd1;
                        ripple_s = 1'b0;
                    end
                end
            end
            // A ripple surviving the top digit means every digit wrapped.
            next_carry_s = ripple_s;
        end else begin
            next_count_s = count_r;
            next_carry_s = 1'b0;
        end
    end

    // Counter value and wrap/borrow pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            carry_r <= 1'b0;
        end else begin
            count_r <= next_count_s;
            carry_r <= next_carry_s;
        end
    end

    // Scan prescaler and digit index, free-running regardless of en/load.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r  <= '0;
            scan_r <= '0;
        end else if (pre_r == PRE_LAST) begin
            pre_r  <= '0;
            scan_r <= (scan_r == IDX_LAST) ? '0 : scan_r + IDX_W'(1);
        end else begin
            pre_r  <= pre_r + PRE_W'(1);
            scan_r <= scan_r;
        end
    end

    // Display path straight from registers so seg tracks count with no added latency.
    always_comb begin
        digit_s   = 4'(count_r >> {scan_r, 2'b00});
        seg_raw_s = seg7_decode(digit_s);
        an_raw_s  = DIGITS'(1'b1) << scan_r;
        if (SEG_ACTIVE_LOW) begin
            seg = ~seg_raw_s;
            an  = ~an_raw_s;
        end else begin
            seg = seg_raw_s;
            an  = an_raw_s;
        end
    end

    assign count = count_r;
    assign carry = carry_r;

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Directed bench: a 4-digit active-high instance and a 2-digit active-low instance.
module tb_bcd_counter_7seg_mux;
    logic        clk = 1'b0;
    logic        reset4, en4, ud4, load4;
    logic [15:0] lv4, count4;
    logic        carry4;
    logic [6:0]  seg4;
    logic [3:0]  an4;
    logic        reset2, en2, ud2, load2;
    logic [7:0]  lv2, count2;
    logic        carry2;
    logic [6:0]  seg2;
    logic [1:0]  an2;

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] exp_seg [4];
    int idx;

    always #5 clk = ~clk;

    bcd_counter_7seg_mux #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut4 (
        .clk(clk), .reset(reset4), .en(en4), .up_down(ud4), .load(load4),
        .load_val(lv4), .count(count4), .carry(carry4), .seg(seg4), .an(an4)
    );

    bcd_counter_7seg_mux #(.DIGITS(2), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .reset(reset2), .en(en2), .up_down(ud2), .load(load2),
        .load_val(lv2), .count(count2), .carry(carry2), .seg(seg2), .an(an2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_seg[0] = 7'b1100110;
        exp_seg[1] = 7'b1001111;
        exp_seg[2] = 7'b1011011;
        exp_seg[3] = 7'b0000110;
        reset4 = 1'b1; en4 = 1'b0; ud4 = 1'b1; load4 = 1'b0; lv4 = 16'h0000;
        reset2 = 1'b1; en2 = 1'b0; ud2 = 1'b1; load2 = 1'b0; lv2 = 8'h00;
        tick();
        tick();
        check("rst_count", count4, 16'h0000);
        check("rst_carry", carry4, 1'b0);
        check("rst_an", an4, 4'b0001);
        check("rst_seg", seg4, 7'b0111111);
        check("rst_an_low", an2, 2'b10);
        check("rst_seg_low", seg2, 7'b1000000);

        // Load then single up step with ripple into digit 1
        reset4 = 1'b0; load4 = 1'b1; lv4 = 16'h0009;
        tick();
        check("load_0009", count4, 16'h0009);
        load4 = 1'b0; en4 = 1'b1; ud4 = 1'b1;
        tick();
        check("up_0010", count4, 16'h0010);
        check("up_carry0", carry4, 1'b0);
        en4 = 1'b0;
        tick();
        check("hold_0010", count4, 16'h0010);
        check("hold_carry", carry4, 1'b0);

        // Load beats enable; nibble A clamps to 0
        load4 = 1'b1; en4 = 1'b1; lv4 = 16'h12A4;
        tick();
        check("load_pri", count4, 16'h1204);
        check("load_pri_carry", carry4, 1'b0);

        // Full 4-digit wrap
        lv4 = 16'h9999;
        tick();
        load4 = 1'b0;
        tick();
        check("wrap4", count4, 16'h0000);
        check("wrap4_carry", carry4, 1'b1);
        en4 = 1'b0;
        tick();
        check("wrap4_pulse", carry4, 1'b0);

        // 2-digit wrap up
        reset2 = 1'b0; load2 = 1'b1; lv2 = 8'h99;
        tick();
        check("load2_99", count2, 8'h99);
        load2 = 1'b0; en2 = 1'b1; ud2 = 1'b1;
        tick();
        check("wrap2", count2, 8'h00);
        check("wrap2_carry", carry2, 1'b1);
        tick();
        check("up2_01", count2, 8'h01);
        check("up2_carry0", carry2, 1'b0);

        // 2-digit borrow down
        en2 = 1'b0; load2 = 1'b1; lv2 = 8'h00;
        tick();
        check("load2_00", count2, 8'h00);
        load2 = 1'b0; en2 = 1'b1; ud2 = 1'b0;
        tick();
        check("borrow2", count2, 8'h99);
        check("borrow2_carry", carry2, 1'b1);
        tick();
        check("down2_98", count2, 8'h98);
        check("down2_carry0", carry2, 1'b0);
        en2 = 1'b0;
        tick();
        check("hold2_98", count2, 8'h98);

        // Upper nibble F clamps, reset beats load
        load2 = 1'b1; lv2 = 8'hF3;
        tick();
        check("load2_clamp", count2, 8'h03);
        reset2 = 1'b1; lv2 = 8'h55;
        tick();
        check("rst_beats_load", count2, 8'h00);
        reset2 = 1'b0; load2 = 1'b0;
        tick();
        check("scan2_an0", an2, 2'b10);
        tick();
        check("scan2_an1", an2, 2'b01);
        check("scan2_seg", seg2, 7'b1000000);

        // Scan 1234 across a full frame after aligning with reset
        reset4 = 1'b1;
        tick();
        reset4 = 1'b0; load4 = 1'b1; lv4 = 16'h1234;
        tick();
        load4 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            idx = (k / 4) % 4;
            check("scan_an", an4, 4'b0001 << idx);
            check("scan_seg", seg4, exp_seg[idx]);
        end
        for (int k = 0; k < 5; k++) tick();
        check("scan_hold", count4, 16'h1234);
        check("scan_mid_an", an4, 4'b0010);

        // Reset in the middle of a frame
        reset4 = 1'b1;
        tick();
        check("midrst_an", an4, 4'b0001);
        check("midrst_count", count4, 16'h0000);
        check("midrst_seg", seg4, 7'b0111111);
        check("midrst_carry", carry4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
